// File: rtl/cashier_pkg.sv
// Shared state type, default widths and accumulator-width helper for the multi-item cashier.
package cashier_pkg;

  typedef enum logic [1:0] {IDLE, MUL, CMP} state_t;

  localparam int unsigned DEF_N_ITEMS = 4;
  localparam int unsigned DEF_PRICE_W = 12;
  localparam int unsigned DEF_NUM_W   = 3;
  localparam int unsigned DEF_PAY_W   = 16;

  // Wide enough for N_ITEMS maximal price*quantity products, so the total never wraps.
  function automatic int unsigned acc_width(input int unsigned n_items,
                                            input int unsigned price_w,
                                            input int unsigned num_w);
    return price_w + num_w + $clog2(n_items) + 1;
  endfunction

endpackage

// File: rtl/seq_mac.sv
// One-bit-per-cycle shift-add accumulate stage shared by all items of a transaction.
// CASHIER_SKIP_ZERO_EN: finish an item as soon as its remaining quantity bits are zero.
module seq_mac #(
  parameter int unsigned PRICE_W = 12,
  parameter int unsigned NUM_W   = 3,
  parameter int unsigned ACC_W   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               start,
  input  logic [PRICE_W-1:0] price,
  input  logic [NUM_W-1:0]   num,
  output logic [ACC_W-1:0]   acc,
  output logic               item_done
);

  localparam int unsigned BIT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  logic [BIT_W-1:0] bit_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] addend;
  logic             cur_bit;

`ifdef CASHIER_SKIP_ZERO_EN
  // Quantity shifted down to the current bit; the item ends once nothing above it remains.
  logic [NUM_W-1:0] rem;
  assign rem       = num >> bit_q;
  assign cur_bit   = rem[0];
  assign item_done = ((rem >> 1) == '0);
`else
  assign cur_bit   = num[bit_q];
  assign item_done = (bit_q == BIT_W'(NUM_W - 1));
`endif

  assign addend = ACC_W'(price) << bit_q;
  assign acc    = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      bit_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
      bit_q <= '0;
    end else if (start) begin
      if (cur_bit) acc_q <= acc_q + addend;
      bit_q <= item_done ? '0 : bit_q + 1'b1;
    end
  end

endmodule

// File: rtl/cashier_multi.sv
// Multi-item cashier: captures payment and N_ITEMS (price, quantity) pairs, totals them with a
// time-shared seq_mac, then reports paid/change. CASHIER_SKIP_ZERO_EN shortens per-item work.
module cashier_multi
  import cashier_pkg::*;
#(
  parameter int unsigned N_ITEMS = DEF_N_ITEMS,
  parameter int unsigned PRICE_W = DEF_PRICE_W,
  parameter int unsigned NUM_W   = DEF_NUM_W,
  parameter int unsigned PAY_W   = DEF_PAY_W,
  localparam int unsigned ACC_W  = acc_width(N_ITEMS, PRICE_W, NUM_W)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic [PAY_W-1:0]           i_payment,
  input  logic [N_ITEMS*PRICE_W-1:0] i_prices,
  input  logic [N_ITEMS*NUM_W-1:0]   i_nums,
  output logic                       o_busy,
  output logic                       o_valid,
  output logic                       o_paid,
  output logic [PAY_W-1:0]           o_change,
  output logic [ACC_W-1:0]           o_total
);

  localparam int unsigned IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int unsigned CMP_W = (ACC_W > PAY_W) ? ACC_W : PAY_W;

  state_t                     state_q;
  logic [PAY_W-1:0]           payment_q;
  logic [N_ITEMS*PRICE_W-1:0] prices_q;
  logic [N_ITEMS*NUM_W-1:0]   nums_q;
  logic [IDX_W-1:0]           idx_q;

  logic [PRICE_W-1:0] price_sel;
  logic [NUM_W-1:0]   num_sel;
  logic [ACC_W-1:0]   acc;
  logic               item_done;
  logic               accept;
  logic               paid;

  assign accept = (state_q == IDLE) && i_enable;
  assign paid   = CMP_W'(payment_q) >= CMP_W'(acc);

  always_comb begin
    price_sel = '0;
    num_sel   = '0;
    for (int k = 0; k < int'(N_ITEMS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        price_sel = prices_q[k*PRICE_W +: PRICE_W];
        num_sel   = nums_q[k*NUM_W +: NUM_W];
      end
    end
  end

  seq_mac #(
    .PRICE_W(PRICE_W),
    .NUM_W  (NUM_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (accept),
    .start    (state_q == MUL),
    .price    (price_sel),
    .num      (num_sel),
    .acc      (acc),
    .item_done(item_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      payment_q <= '0;
      prices_q  <= '0;
      nums_q    <= '0;
      idx_q     <= '0;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_paid    <= 1'b0;
      o_change  <= '0;
      o_total   <= '0;
    end else begin
      // Result strobe and paid/change last one cycle; o_total holds.
      o_valid  <= 1'b0;
      o_paid   <= 1'b0;
      o_change <= '0;
      unique case (state_q)
        IDLE: begin
          if (i_enable) begin
            payment_q <= i_payment;
            prices_q  <= i_prices;
            nums_q    <= i_nums;
            idx_q     <= '0;
            o_busy    <= 1'b1;
            state_q   <= MUL;
          end
        end
        MUL: begin
          if (item_done) begin
            if (idx_q == IDX_W'(N_ITEMS - 1)) state_q <= CMP;
            else                              idx_q   <= idx_q + 1'b1;
          end
        end
        CMP: begin
          // Truncated subtraction is exact whenever payment covers the total.
          o_paid   <= paid;
          o_change <= paid ? (payment_q - PAY_W'(acc)) : '0;
          o_total  <= acc;
          o_valid  <= 1'b1;
          o_busy   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cashier_multi.sv
// Directed self-checking bench for cashier_multi at default parameters.
module tb_cashier_multi;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic [15:0] i_payment;
  logic [47:0] i_prices;
  logic [11:0] i_nums;
  logic        o_busy;
  logic        o_valid;
  logic        o_paid;
  logic [15:0] o_change;
  logic [17:0] o_total;

  int pass_cnt = 0;
  int total_cnt = 0;

  cashier_multi dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .i_payment(i_payment),
    .i_prices (i_prices),
    .i_nums   (i_nums),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_paid   (o_paid),
    .o_change (o_change),
    .o_total  (o_total)
  );

  always #5 i_clk = ~i_clk;

  // Expected cycles from acceptance edge to the o_valid edge.
  function automatic int exp_lat(input logic [11:0] nums);
`ifdef CASHIER_SKIP_ZERO_EN
    int s;
    logic [2:0] n;
    int c;
    s = 1;
    for (int k = 0; k < 4; k++) begin
      n = nums[k*3 +: 3];
      c = 1;
      for (int b = 0; b < 3; b++) if (n[b]) c = b + 1;
      s += c;
    end
    return s;
`else
    return 13;
`endif
  endfunction

  // Present a transaction, pulse i_enable across one edge; returns just after the accept edge.
  task automatic accept_txn(input logic [15:0] pay, input logic [47:0] prices,
                            input logic [11:0] nums);
    i_payment = pay;
    i_prices  = prices;
    i_nums    = nums;
    i_enable  = 1'b1;
    @(posedge i_clk);
    #1;
    i_enable  = 1'b0;
    i_payment = 16'hffff;
    i_prices  = '1;
    i_nums    = '1;
  endtask

  // Count edges until o_valid, and samples with o_busy high (including the one after accept).
  task automatic wait_valid(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = o_busy ? 1 : 0;
    while (!o_valid && cycles < 100) begin
      @(posedge i_clk);
      #1;
      cycles++;
      if (o_busy) busy_cnt++;
    end
    if (!o_valid) cycles = -1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_enable = 1'b0; i_payment = '0; i_prices = '0; i_nums = '0;
    #12;
    total_cnt++;
    if ({o_busy, o_valid, o_paid, o_change, o_total} !== '0)
      $display("FAIL reset_outputs got busy=%0b valid=%0b paid=%0b change=%0d total=%0d want all 0",
               o_busy, o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_basic();
    int cyc, busy;
    accept_txn(16'd5000, {12'd400, 12'd300, 12'd200, 12'd100}, {3'd4, 3'd3, 3'd2, 3'd1});
    wait_valid(cyc, busy);
    total_cnt++;
    if (cyc !== exp_lat(12'b100_011_010_001))
      $display("FAIL basic_latency got %0d want %0d", cyc, exp_lat(12'b100_011_010_001));
    else pass_cnt++;
    total_cnt++;
    if (busy !== exp_lat(12'b100_011_010_001))
      $display("FAIL basic_busy_cycles got %0d want %0d", busy, exp_lat(12'b100_011_010_001));
    else pass_cnt++;
    total_cnt++;
    if ({o_paid, o_change, o_total} !== {1'b1, 16'd2000, 18'd3000})
      $display("FAIL basic_result got paid=%0b change=%0d total=%0d want 1/2000/3000",
               o_paid, o_change, o_total);
    else pass_cnt++;
    @(posedge i_clk);
    #1;
    total_cnt++;
    if ({o_valid, o_paid, o_change, o_total} !== {1'b0, 1'b0, 16'd0, 18'd3000})
      $display("FAIL basic_after got valid=%0b paid=%0b change=%0d total=%0d want 0/0/0/3000",
               o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    int cyc, busy;
    accept_txn(16'd2999, {12'd400, 12'd300, 12'd200, 12'd100}, {3'd4, 3'd3, 3'd2, 3'd1});
    wait_valid(cyc, busy);
    total_cnt++;
    if ({o_valid, o_paid, o_change, o_total} !== {1'b1, 1'b0, 16'd0, 18'd3000})
      $display("FAIL short_by_one got valid=%0b paid=%0b change=%0d total=%0d want 1/0/0/3000",
               o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    @(posedge i_clk);
    #1;
    accept_txn(16'd3000, {12'd400, 12'd300, 12'd200, 12'd100}, {3'd4, 3'd3, 3'd2, 3'd1});
    wait_valid(cyc, busy);
    total_cnt++;
    if ({o_valid, o_paid, o_change, o_total} !== {1'b1, 1'b1, 16'd0, 18'd3000})
      $display("FAIL exact_payment got valid=%0b paid=%0b change=%0d total=%0d want 1/1/0/3000",
               o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_max();
    int cyc, busy;
    accept_txn(16'd65535, {4{12'd4095}}, {4{3'd7}});
    wait_valid(cyc, busy);
    total_cnt++;
    if ({o_valid, o_paid, o_change, o_total} !== {1'b1, 1'b0, 16'd0, 18'd114660})
      $display("FAIL max_total got valid=%0b paid=%0b change=%0d total=%0d want 1/0/0/114660",
               o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cyc, busy, lat_a;
    lat_a = exp_lat(12'b100_011_010_001);
    accept_txn(16'd5000, {12'd400, 12'd300, 12'd200, 12'd100}, {3'd4, 3'd3, 3'd2, 3'd1});
    cyc = 0;
    while (!o_valid && cyc < 100) begin
      if (cyc == 3 || cyc == lat_a - 1) begin
        i_enable = 1'b1; i_payment = 16'd1; i_prices = '0; i_nums = '0;
      end else begin
        i_enable = 1'b0;
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_enable = 1'b0;
    total_cnt++;
    if (cyc !== lat_a) $display("FAIL ignore_latency got %0d want %0d", cyc, lat_a);
    else pass_cnt++;
    total_cnt++;
    if ({o_valid, o_paid, o_change, o_total} !== {1'b1, 1'b1, 16'd2000, 18'd3000})
      $display("FAIL ignore_result got valid=%0b paid=%0b change=%0d total=%0d want 1/1/2000/3000",
               o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    // Accept B in the o_valid cycle.
    accept_txn(16'd100, {12'd4, 12'd3, 12'd2, 12'd1}, {4{3'd7}});
    total_cnt++;
    if (o_busy !== 1'b1) $display("FAIL b2b_accept got busy=%0b want 1", o_busy);
    else pass_cnt++;
    wait_valid(cyc, busy);
    total_cnt++;
    if (cyc !== 13) $display("FAIL b2b_latency got %0d want 13", cyc);
    else pass_cnt++;
    total_cnt++;
    if ({o_valid, o_paid, o_change, o_total} !== {1'b1, 1'b1, 16'd30, 18'd70})
      $display("FAIL b2b_result got valid=%0b paid=%0b change=%0d total=%0d want 1/1/30/70",
               o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int cyc, busy, seen;
    accept_txn(16'd5000, {12'd400, 12'd300, 12'd200, 12'd100}, {3'd4, 3'd3, 3'd2, 3'd1});
    repeat (5) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    total_cnt++;
    if ({o_busy, o_valid, o_paid, o_change, o_total} !== '0)
      $display("FAIL midreset_outputs got busy=%0b valid=%0b paid=%0b change=%0d total=%0d want 0",
               o_busy, o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    @(negedge i_clk);
    i_rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge i_clk);
      #1;
      if (o_valid || o_busy) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL midreset_no_valid got %0d active cycles want 0", seen);
    else pass_cnt++;
    accept_txn(16'd15, {12'd0, 12'd0, 12'd0, 12'd10}, {3'd0, 3'd0, 3'd0, 3'd1});
    wait_valid(cyc, busy);
    total_cnt++;
    if (cyc !== exp_lat(12'b000_000_000_001))
      $display("FAIL post_reset_latency got %0d want %0d", cyc, exp_lat(12'b000_000_000_001));
    else pass_cnt++;
    total_cnt++;
    if ({o_valid, o_paid, o_change, o_total} !== {1'b1, 1'b1, 16'd5, 18'd10})
      $display("FAIL post_reset_result got valid=%0b paid=%0b change=%0d total=%0d want 1/1/5/10",
               o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_skip_zero();
    int cyc, busy;
    accept_txn(16'd400, {12'd80, 12'd70, 12'd60, 12'd50}, {3'd4, 3'd0, 3'd1, 3'd0});
    wait_valid(cyc, busy);
    total_cnt++;
    if (cyc !== exp_lat(12'b100_000_001_000))
      $display("FAIL zero_qty_latency got %0d want %0d", cyc, exp_lat(12'b100_000_001_000));
    else pass_cnt++;
    total_cnt++;
    if ({o_valid, o_paid, o_change, o_total} !== {1'b1, 1'b1, 16'd20, 18'd380})
      $display("FAIL zero_qty_result got valid=%0b paid=%0b change=%0d total=%0d want 1/1/20/380",
               o_valid, o_paid, o_change, o_total);
    else pass_cnt++;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_max();
    test_back_to_back();
    test_reset_mid();
    test_skip_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
